// File: rtl/seq_det_frame_ctrl.sv
// Frame sequencer for a bit-serial Moore detector: takes one parallel word, clears the detector,
// shifts the word out MSB-first, counts detector hits and returns the count to a consumer.
module seq_det_frame_ctrl #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  input  logic              abort,
  output logic              det_rst,
  output logic              det_din,
  output logic              det_valid,
  input  logic              seq_det,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  input  logic              res_ready
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} state_t;

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [BC_W-1:0]  LAST_BIT   = BC_W'(DATA_W);
  localparam logic [DC_W-1:0]  LAST_DRAIN = DC_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [DC_W-1:0]   drain_cnt;
  logic              count_en;
  logic              in_frame;
  logic [CNT_W-1:0]  cnt_next;
  logic              sat_next;

  // Detector output only matters while a frame is on the wire or draining.
  assign in_frame = (state == CLR) || (state == SHIFT) || (state == DRAIN);
  assign count_en = ((state == SHIFT) || (state == DRAIN)) && seq_det;

  always_comb begin
    cnt_next = res_count;
    sat_next = res_sat;
    if (count_en && (res_count != CNT_MAX)) begin
      cnt_next = res_count + CNT_W'(1);
    end
    if (count_en && (cnt_next == CNT_MAX)) begin
      sat_next = 1'b1;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid and its data stay stable until that edge, ready may change freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_ready <= 1'b0;
      det_rst    <= 1'b1;
      det_din    <= 1'b0;
      det_valid  <= 1'b0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_sat    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      drain_cnt  <= '0;
    end else if (abort && in_frame) begin
      state      <= IDLE;
      word_ready <= 1'b1;
      det_rst    <= 1'b1;
      det_din    <= 1'b0;
      det_valid  <= 1'b0;
      res_count  <= '0;
      res_sat    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          det_rst    <= 1'b0;
          det_din    <= 1'b0;
          det_valid  <= 1'b0;
          word_ready <= 1'b1;
          if (word_valid && word_ready) begin
            shreg      <= word_data;
            word_ready <= 1'b0;
            det_rst    <= 1'b1;
            res_count  <= '0;
            res_sat    <= 1'b0;
            state      <= CLR;
          end
        end
        CLR: begin
          det_rst   <= 1'b0;
          det_valid <= 1'b1;
          det_din   <= shreg[DATA_W-1];
          shreg     <= shreg << 1;
          bit_cnt   <= BC_W'(1);
          state     <= SHIFT;
        end
        SHIFT: begin
          res_count <= cnt_next;
          res_sat   <= sat_next;
          if (bit_cnt == LAST_BIT) begin
            det_valid <= 1'b0;
            det_din   <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            det_din <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        DRAIN: begin
          // The last bit's detection arrives one cycle late, so drain cycles still count.
          res_count <= cnt_next;
          res_sat   <= sat_next;
          if (drain_cnt == LAST_DRAIN) begin
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            word_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// Bench for seq_det_frame_ctrl: stub detector, directed and randomized frames, popcount reference model.
module tb_seq_det_frame_ctrl;
  localparam int DATA_W    = 16;
  localparam int DRAIN_CYC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic word_valid = 1'b0;
  logic [DATA_W-1:0] word_data = '0;
  logic abort = 1'b0;
  logic res_ready = 1'b0;

  logic word_ready_a, det_rst_a, det_din_a, det_valid_a, res_valid_a, res_sat_a;
  logic [7:0] res_count_a;
  logic seq_det_a = 1'b0;
  logic word_ready_s, det_rst_s, det_din_s, det_valid_s, res_valid_s, res_sat_s;
  logic [2:0] res_count_s;
  logic seq_det_s = 1'b0;

  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_det_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(8), .DRAIN_CYC(DRAIN_CYC)) u_dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready_a), .abort(abort), .det_rst(det_rst_a), .det_din(det_din_a),
    .det_valid(det_valid_a), .seq_det(seq_det_a), .res_valid(res_valid_a),
    .res_count(res_count_a), .res_sat(res_sat_a), .res_ready(res_ready)
  );

  seq_det_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(3), .DRAIN_CYC(DRAIN_CYC)) u_sat (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready_s), .abort(abort), .det_rst(det_rst_s), .det_din(det_din_s),
    .det_valid(det_valid_s), .seq_det(seq_det_s), .res_valid(res_valid_s),
    .res_count(res_count_s), .res_sat(res_sat_s), .res_ready(res_ready)
  );

  // Stub detector: a hit one cycle after every sampled '1' bit.
  always @(posedge clk) begin
    seq_det_a <= det_valid_a && det_din_a;
    seq_det_s <= det_valid_s && det_din_s;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ones(input logic [DATA_W-1:0] d);
    int n = 0;
    for (int i = 0; i < DATA_W; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic int exp_cnt(input logic [DATA_W-1:0] d, input int w);
    int mx = (1 << w) - 1;
    return (ones(d) > mx) ? mx : ones(d);
  endfunction

  function automatic int exp_sat(input logic [DATA_W-1:0] d, input int w);
    return (ones(d) >= (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !word_ready_a; i++) step();
    check("wait_ready", 32'(word_ready_a), 1);
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] data, input int bp);
    logic [DATA_W-1:0] d;
    wait_ready();
    word_valid = 1'b1;
    word_data  = data;
    abort      = 1'($urandom_range(0, 1));
    exp_q.push_back(data);
    step();
    word_valid = 1'b0;
    abort      = 1'b0;
    word_data  = DATA_W'($urandom);
    check("clr_det_rst", 32'(det_rst_a), 1);
    check("clr_word_ready", 32'(word_ready_a), 0);
    check("clr_det_valid", 32'(det_valid_a), 0);
    for (int i = 0; i < DATA_W; i++) begin
      step();
      check("shift_valid", 32'(det_valid_a), 1);
      check("shift_din", 32'(det_din_a), 32'(data[DATA_W-1-i]));
      check("shift_det_rst", 32'(det_rst_a), 0);
    end
    for (int i = 0; i < DRAIN_CYC; i++) begin
      step();
      check("drain_valid", 32'(det_valid_a), 0);
      check("drain_res_valid", 32'(res_valid_a), 0);
    end
    step();
    d = exp_q.pop_front();
    check("res_valid", 32'(res_valid_a), 1);
    check("res_count", 32'(res_count_a), 32'(exp_cnt(d, 8)));
    check("res_sat", 32'(res_sat_a), 32'(exp_sat(d, 8)));
    check("res_count_w3", 32'(res_count_s), 32'(exp_cnt(d, 3)));
    check("res_sat_w3", 32'(res_sat_s), 32'(exp_sat(d, 3)));
    check("report_word_ready", 32'(word_ready_a), 0);
    for (int i = 0; i < bp; i++) begin
      word_valid = 1'b1;
      word_data  = DATA_W'($urandom);
      abort      = 1'($urandom_range(0, 1));
      step();
      check("bp_res_valid", 32'(res_valid_a), 1);
      check("bp_res_count", 32'(res_count_a), 32'(exp_cnt(d, 8)));
      check("bp_word_ready", 32'(word_ready_a), 0);
      check("bp_det_rst", 32'(det_rst_a), 0);
    end
    abort     = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready  = 1'b0;
    word_valid = 1'b0;
    check("release_res_valid", 32'(res_valid_a), 0);
    check("release_word_ready", 32'(word_ready_a), 1);
    check("idle_count_hold", 32'(res_count_a), 32'(exp_cnt(d, 8)));
  endtask

  // pos 0 is the CLR cycle, 1..DATA_W the SHIFT cycles, beyond that DRAIN.
  task automatic abort_frame(input logic [DATA_W-1:0] data, input int pos);
    wait_ready();
    word_valid = 1'b1;
    word_data  = data;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < pos; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_det_rst", 32'(det_rst_a), 1);
    check("abort_det_valid", 32'(det_valid_a), 0);
    check("abort_res_valid", 32'(res_valid_a), 0);
    check("abort_word_ready", 32'(word_ready_a), 1);
    check("abort_count_clr", 32'(res_count_a), 0);
    step();
    check("abort_det_rst_drop", 32'(det_rst_a), 0);
    check("abort_no_result", 32'(res_valid_a), 0);
  endtask

  task automatic reset_in_drain();
    wait_ready();
    word_valid = 1'b1;
    word_data  = 16'hFFFF;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < DATA_W + 1; i++) step();
    check("pre_rst_in_drain", 32'(det_valid_a), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("drain_rst_det_rst", 32'(det_rst_a), 1);
    check("drain_rst_count", 32'(res_count_a), 0);
    check("drain_rst_ready", 32'(word_ready_a), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_rst_no_result", 32'(res_valid_a), 0);
    end
    check("drain_rst_ready_after", 32'(word_ready_a), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_word_ready", 32'(word_ready_a), 0);
      check("rst_det_rst", 32'(det_rst_a), 1);
      check("rst_det_valid", 32'(det_valid_a), 0);
      check("rst_det_din", 32'(det_din_a), 0);
      check("rst_res_valid", 32'(res_valid_a), 0);
      check("rst_res_count", 32'(res_count_a), 0);
      check("rst_res_sat", 32'(res_sat_a), 0);
    end
    rst = 1'b0;
    step();
    check("post_rst_word_ready", 32'(word_ready_a), 1);
    check("post_rst_det_rst", 32'(det_rst_a), 0);

    run_frame(16'hA5A5, 0);
    run_frame(16'h0000, 0);
    run_frame(16'hFFFF, 0);
    run_frame(16'h1234, 5);
    abort_frame(16'hFFFF, 6);
    run_frame(16'h000F, 0);
    reset_in_drain();
    run_frame(16'h8001, 2);
    abort_frame(16'hFFFF, 0);
    abort_frame(16'hFFFF, DATA_W + DRAIN_CYC);

    for (int n = 0; n < 40; n++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        word_data = DATA_W'($urandom);
        abort     = 1'($urandom_range(0, 1));
        step();
        check("gap_res_valid", 32'(res_valid_a), 0);
      end
      abort = 1'b0;
      if ($urandom_range(0, 9) == 0)
        abort_frame(DATA_W'($urandom), $urandom_range(0, DATA_W + DRAIN_CYC));
      else
        run_frame(DATA_W'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
